// File: rtl/loopback_channel_if.sv
// Sample stream bundle between Tx DAC, loopback channel and Rx ADC.
// master drives the DAC side, slave is the channel.
interface loopback_channel_if #(
  parameter int DATA_W = 12
);
  logic signed [DATA_W-1:0] DAC_I;
  logic signed [DATA_W-1:0] DAC_Q;
  logic                     DAC_valid;
  logic signed [DATA_W-1:0] ADC_I;
  logic signed [DATA_W-1:0] ADC_Q;
  logic                     ADC_valid;

  modport master (
    output DAC_I, DAC_Q, DAC_valid,
    input  ADC_I, ADC_Q, ADC_valid
  );

  modport slave (
    input  DAC_I, DAC_Q, DAC_valid,
    output ADC_I, ADC_Q, ADC_valid
  );
endinterface

// File: rtl/loopback_channel.sv
// Digital DAC-to-ADC loopback channel: rotation, gain,
// offset, LFSR noise and a sample-indexed delay line.
module loopback_channel #(
  parameter int          DATA_W    = 12,
  parameter int          DELAY_MAX = 16,
  parameter int          NOISE_W   = 6,
  parameter logic [15:0] SEED_I    = 16'hACE1,
  parameter logic [15:0] SEED_Q    = 16'h1D87
) (
  input  logic                         clk_32M768,
  input  logic                         rst_32M768,
  loopback_channel_if.slave            bus,
  input  logic [1:0]                   CH_ROT,
  input  logic [3:0]                   CH_GAIN,
  input  logic signed [DATA_W-1:0]     CH_OFFSET,
  input  logic [$clog2(DELAY_MAX)-1:0] CH_DELAY,
  input  logic                         CH_NOISE_EN
);
  localparam int AW = $clog2(DELAY_MAX);
  localparam int PW = DATA_W + 5;

  typedef logic signed [DATA_W-1:0] smp_t;
  typedef logic signed [PW-1:0]     wide_t;

  localparam smp_t DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam smp_t DMIN = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic smp_t neg_sat(smp_t x);
    return (x == DMIN) ? DMAX : -x;
  endfunction

  function automatic smp_t sat(wide_t x);
    if (x > wide_t'(DMAX)) return DMAX;
    if (x < wide_t'(DMIN)) return DMIN;
    return x[DATA_W-1:0];
  endfunction

  // Galois form, taps for x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  logic          s1_v, s2_v;
  smp_t          s1_i, s1_q, s2_i, s2_q;
  logic [15:0]   lfsr_i, lfsr_q;
  smp_t          dly_i [DELAY_MAX];
  smp_t          dly_q [DELAY_MAX];
  logic [AW-1:0] wp;

  smp_t          rot_i, rot_q;
  smp_t          gain_i, gain_q;
  smp_t          sum_i, sum_q;
  smp_t          out_i, out_q;
  wide_t         prod_i, prod_q;
  wide_t         n_i, n_q;
  logic [AW-1:0] rp;

  always_comb begin
    rot_i = bus.DAC_I;
    rot_q = bus.DAC_Q;
    unique case (CH_ROT)
      2'd0: ;
      2'd1: begin
        rot_i = bus.DAC_Q;
        rot_q = neg_sat(bus.DAC_I);
      end
      2'd2: begin
        rot_i = neg_sat(bus.DAC_I);
        rot_q = neg_sat(bus.DAC_Q);
      end
      2'd3: begin
        rot_i = neg_sat(bus.DAC_Q);
        rot_q = bus.DAC_I;
      end
    endcase
  end

  always_comb begin
    prod_i = wide_t'(s1_i) * wide_t'({1'b0, CH_GAIN});
    prod_q = wide_t'(s1_q) * wide_t'({1'b0, CH_GAIN});
    gain_i = sat(prod_i >>> 2);
    gain_q = sat(prod_q >>> 2);
  end

  always_comb begin
    n_i   = CH_NOISE_EN ? wide_t'(lfsr_i[NOISE_W-1:0]) : '0;
    n_q   = CH_NOISE_EN ? wide_t'(lfsr_q[NOISE_W-1:0]) : '0;
    sum_i = sat(wide_t'(s2_i) + wide_t'(CH_OFFSET) + n_i);
    sum_q = sat(wide_t'(s2_q) + wide_t'(CH_OFFSET) + n_q);
    // read position is sample-indexed, taken before this write
    rp    = wp - CH_DELAY;
    out_i = (CH_DELAY == '0) ? sum_i : dly_i[rp];
    out_q = (CH_DELAY == '0) ? sum_q : dly_q[rp];
  end

  always_ff @(posedge clk_32M768) begin
    if (rst_32M768) begin
      s1_v          <= 1'b0;
      s2_v          <= 1'b0;
      s1_i          <= '0;
      s1_q          <= '0;
      s2_i          <= '0;
      s2_q          <= '0;
      lfsr_i        <= SEED_I;
      lfsr_q        <= SEED_Q;
      wp            <= '0;
      bus.ADC_valid <= 1'b0;
      bus.ADC_I     <= '0;
      bus.ADC_Q     <= '0;
      for (int k = 0; k < DELAY_MAX; k++) begin
        dly_i[k] <= '0;
        dly_q[k] <= '0;
      end
    end else begin
      s1_v <= bus.DAC_valid;
      if (bus.DAC_valid) begin
        s1_i <= rot_i;
        s1_q <= rot_q;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_i <= gain_i;
        s2_q <= gain_q;
      end
      bus.ADC_valid <= s2_v;
      bus.ADC_I     <= s2_v ? out_i : '0;
      bus.ADC_Q     <= s2_v ? out_q : '0;
      if (s2_v) begin
        lfsr_i    <= lfsr_step(lfsr_i);
        lfsr_q    <= lfsr_step(lfsr_q);
        dly_i[wp] <= sum_i;
        dly_q[wp] <= sum_q;
        wp        <= wp + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_loopback_channel.sv
// Self-checking bench for loopback_channel: vector table,
// corner sequences and random traffic against a sample model.
module tb_loopback_channel;
  localparam int DATA_W  = 12;
  localparam int NOISE_W = 6;
  localparam int SEED_I  = 'hACE1;
  localparam int SEED_Q  = 'h1D87;

  logic        clk_32M768 = 1'b0;
  logic        rst_32M768 = 1'b1;
  logic [1:0]  ch_rot     = '0;
  logic [3:0]  ch_gain    = 4'd4;
  logic signed [DATA_W-1:0] ch_offset = '0;
  logic [3:0]  ch_delay   = '0;
  logic        ch_noise_en = 1'b0;

  loopback_channel_if #(.DATA_W(DATA_W)) bus ();

  loopback_channel dut (
    .clk_32M768  (clk_32M768),
    .rst_32M768  (rst_32M768),
    .bus         (bus),
    .CH_ROT      (ch_rot),
    .CH_GAIN     (ch_gain),
    .CH_OFFSET   (ch_offset),
    .CH_DELAY    (ch_delay),
    .CH_NOISE_EN (ch_noise_en)
  );

  always #5 clk_32M768 = ~clk_32M768;

  typedef struct { int due; int i; int q; } exp_t;
  typedef struct {
    int rot; int gain; int off;
    int di;  int dq;   int ei; int eq;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  int   hi[$];
  int   hq[$];
  int   li, lq;
  bit   cap_en = 1'b0;
  int   cap_i[$];
  int   cap_q[$];

  always @(posedge clk_32M768) cyc <= cyc + 1;

  function automatic int sat(int x);
    if (x > 2047) return 2047;
    if (x < -2048) return -2048;
    return x;
  endfunction

  function automatic int nsat(int x);
    return sat(-x);
  endfunction

  function automatic int lstep(int s);
    return (s & 1) ? ((s >> 1) ^ 'hB400) : (s >> 1);
  endfunction

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic model_push(input int i, input int q);
    int ri, rq, si, sq, oi, oq, k, d, mask;
    case (ch_rot)
      2'd0: begin ri = i;       rq = q;       end
      2'd1: begin ri = q;       rq = nsat(i); end
      2'd2: begin ri = nsat(i); rq = nsat(q); end
      default: begin ri = nsat(q); rq = i;  end
    endcase
    ri = sat((ri * int'(ch_gain)) >>> 2);
    rq = sat((rq * int'(ch_gain)) >>> 2);
    mask = (1 << NOISE_W) - 1;
    si = sat(ri + int'(ch_offset) + (ch_noise_en ? (li & mask) : 0));
    sq = sat(rq + int'(ch_offset) + (ch_noise_en ? (lq & mask) : 0));
    li = lstep(li);
    lq = lstep(lq);
    k = hi.size();
    d = int'(ch_delay);
    if (d == 0) begin
      oi = si; oq = sq;
    end else if (k >= d) begin
      oi = hi[k-d]; oq = hq[k-d];
    end else begin
      oi = 0; oq = 0;
    end
    hi.push_back(si);
    hq.push_back(sq);
    sb.push_back('{cyc + 3, oi, oq});
  endtask

  task automatic tick();
    @(posedge clk_32M768);
    #1;
  endtask

  task automatic drive(input bit v, input int i, input int q);
    bus.DAC_valid = v;
    bus.DAC_I     = DATA_W'(i);
    bus.DAC_Q     = DATA_W'(q);
    if (v) model_push(i, q);
    tick();
  endtask

  task automatic do_reset(input int n);
    exp_t keep[$];
    rst_32M768    = 1'b1;
    bus.DAC_valid = 1'b0;
    bus.DAC_I     = '0;
    bus.DAC_Q     = '0;
    foreach (sb[k]) if (sb[k].due <= cyc) keep.push_back(sb[k]);
    sb = keep;
    hi.delete();
    hq.delete();
    li = SEED_I;
    lq = SEED_Q;
    repeat (n) tick();
    check("reset_valid", int'(bus.ADC_valid), 0);
    check("reset_i", int'(bus.ADC_I), 0);
    check("reset_q", int'(bus.ADC_Q), 0);
    rst_32M768 = 1'b0;
  endtask

  task automatic set_cfg(input int rot, input int gain, input int off,
                         input int dly, input bit nen);
    ch_rot      = 2'(rot);
    ch_gain     = 4'(gain);
    ch_offset   = DATA_W'(off);
    ch_delay    = 4'(dly);
    ch_noise_en = nen;
  endtask

  always @(negedge clk_32M768) begin
    int ev, ei, eq;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed due=%0d cyc=%0d", sb[0].due, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      ev = 1; ei = sb[0].i; eq = sb[0].q;
      void'(sb.pop_front());
    end else begin
      ev = 0; ei = 0; eq = 0;
    end
    checks++;
    if (int'(bus.ADC_valid) != ev || int'(bus.ADC_I) != ei ||
        int'(bus.ADC_Q) != eq) begin
      errors++;
      $display("FAIL out cyc=%0d got v=%0d i=%0d q=%0d want v=%0d i=%0d q=%0d",
               cyc, bus.ADC_valid, bus.ADC_I, bus.ADC_Q, ev, ei, eq);
    end
    if (cap_en && bus.ADC_valid) begin
      cap_i.push_back(int'(bus.ADC_I));
      cap_q.push_back(int'(bus.ADC_Q));
    end
  end

  initial begin
    vec_t vt[$];
    int   run1[$];
    int   bad, sum, i, q;
    bus.DAC_valid = 1'b0;
    bus.DAC_I     = '0;
    bus.DAC_Q     = '0;
    li = SEED_I;
    lq = SEED_Q;

    vt.push_back('{0,  4,    0,   100,   -50,   100,   -50});
    vt.push_back('{1,  3,  -16,  1000,   400,   284,  -766});
    vt.push_back('{0, 15,    0,  2047,     0,  2047,     0});
    vt.push_back('{2,  4,    0, -2048,     0,  2047,     0});
    vt.push_back('{0, 15, -100, -2048,     5, -2048,   -82});
    vt.push_back('{3,  4,    0,    10,    20,   -20,    10});
    vt.push_back('{0,  0,    0,   500,  -500,     0,     0});
    vt.push_back('{0,  1,    0,    -3,     3,    -1,     0});
    vt.push_back('{1,  4,    0,     5, -2048, -2048,    -5});
    vt.push_back('{3,  4,    0,     7, -2048,  2047,     7});
    vt.push_back('{0,  4, 2000,  1000, -1000,  2047,  1000});

    do_reset(2);
    foreach (vt[k]) begin
      set_cfg(vt[k].rot, vt[k].gain, vt[k].off, 0, 1'b0);
      drive(1'b1, vt[k].di, vt[k].dq);
      drive(1'b0, 0, 0);
      drive(1'b0, 0, 0);
      check($sformatf("vec%0d_valid", k), int'(bus.ADC_valid), 1);
      check($sformatf("vec%0d_i", k), int'(bus.ADC_I), vt[k].ei);
      check($sformatf("vec%0d_q", k), int'(bus.ADC_Q), vt[k].eq);
      drive(1'b0, 0, 0);
    end

    // impulse through a 5-sample delay
    do_reset(1);
    set_cfg(0, 4, 0, 5, 1'b0);
    cap_i.delete(); cap_q.delete(); cap_en = 1'b1;
    for (int k = 0; k < 20; k++) drive(1'b1, (k == 10) ? 500 : 0, 0);
    repeat (4) drive(1'b0, 0, 0);
    cap_en = 1'b0;
    check("imp_count", cap_i.size(), 20);
    if (cap_i.size() == 20) begin
      check("imp_out15", cap_i[15], 500);
      bad = 0;
      for (int k = 0; k < 20; k++)
        if (k != 15 && (cap_i[k] != 0 || cap_q[k] != 0)) bad++;
      check("imp_others_zero", bad, 0);
    end

    // noise statistics and reproducibility after reset
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(1);
      set_cfg(0, 4, -32, 0, 1'b1);
      cap_i.delete(); cap_q.delete(); cap_en = 1'b1;
      for (int k = 0; k < 4096; k++) drive(1'b1, 0, 0);
      repeat (4) drive(1'b0, 0, 0);
      cap_en = 1'b0;
      check("noise_count", cap_i.size(), 4096);
      bad = 0;
      sum = 0;
      foreach (cap_i[k]) begin
        if (cap_i[k] < -32 || cap_i[k] > 31) bad++;
        if (cap_q[k] < -32 || cap_q[k] > 31) bad++;
        sum += cap_i[k];
      end
      check("noise_range", bad, 0);
      check("noise_mean_i_ok", int'((2*sum + 4096) <= 4*4096 &&
                                    (2*sum + 4096) >= -4*4096), 1);
      if (pass == 0) begin
        run1 = cap_i;
      end else begin
        bad = 0;
        foreach (cap_i[k]) if (k >= run1.size() || run1[k] != cap_i[k]) bad++;
        check("noise_repeat", bad, 0);
      end
    end

    // one-cycle reset inside a continuous stream
    do_reset(1);
    set_cfg(0, 4, 0, 3, 1'b0);
    for (int k = 0; k < 20; k++) drive(1'b1, k + 1, -(k + 1));
    do_reset(1);
    cap_i.delete(); cap_q.delete(); cap_en = 1'b1;
    for (int k = 0; k < 10; k++) drive(1'b1, 100 + k, 0);
    repeat (4) drive(1'b0, 0, 0);
    cap_en = 1'b0;
    check("rst_count", cap_i.size(), 10);
    if (cap_i.size() == 10) begin
      bad = 0;
      for (int k = 0; k < 3; k++) if (cap_i[k] != 0 || cap_q[k] != 0) bad++;
      check("rst_first3_zero", bad, 0);
      check("rst_out3", cap_i[3], 100);
    end

    // randomized traffic against the model
    for (int blk = 0; blk < 30; blk++) begin
      if ($urandom_range(0, 5) == 0) do_reset(1);
      set_cfg($urandom_range(0, 3), $urandom_range(0, 15),
              $urandom_range(0, 4095) - 2048, $urandom_range(0, 15),
              1'($urandom_range(0, 1)));
      for (int k = 0; k < 100; k++) begin
        case ($urandom_range(0, 5))
          0: i = -2048;
          1: i = 2047;
          default: i = $urandom_range(0, 4095) - 2048;
        endcase
        q = $urandom_range(0, 4095) - 2048;
        if ($urandom_range(0, 199) == 0) do_reset(1);
        drive(1'($urandom_range(0, 3) != 0), i, q);
      end
      repeat (4) drive(1'b0, 0, 0);
    end

    repeat (4) drive(1'b0, 0, 0);
    check("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
